// File: rtl/fill_seal_ctrl_if.sv
// Operator-panel, sensor and actuator signals of the fill-and-seal station.
// The controller takes the slave side; the panel/plant model takes the master side.
interface fill_seal_ctrl_if;
  logic       en;
  logic       pg;
  logic       ch;
  logic       ro;
  logic       ack;
  logic       motor;
  logic       ev;
  logic       ved;
  logic       done;
  logic       erro;
  logic [7:0] count;

  modport master (
    output en, pg, ch, ro, ack,
    input  motor, ev, ved, done, erro, count
  );

  modport slave (
    input  en, pg, ch, ro, ack,
    output motor, ev, ved, done, erro, count
  );
endinterface

// File: rtl/fill_seal_ctrl.sv
// Bottle fill-and-seal station sequencer: convey, fill with timeout, seal for a
// fixed time, release, with a latched fault that needs an operator acknowledge.
module fill_seal_ctrl #(
  parameter int FILL_TMO = 1000,
  parameter int SEAL_CYC = 8,
  parameter int TMR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  fill_seal_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVEY  = 3'd1,
    FILL    = 3'd2,
    SEAL    = 3'd3,
    RELEASE = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [TMR_W-1:0] FILL_LAST = TMR_W'(FILL_TMO - 1);
  localparam logic [TMR_W-1:0] SEAL_LAST = TMR_W'(SEAL_CYC - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             done;
  logic [7:0]       count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      done  <= 1'b0;
      count <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) state <= CONVEY;
        end
        CONVEY: begin
          if (bus.pg) begin
            state <= FILL;
            timer <= '0;
          end else if (!bus.en) begin
            state <= IDLE;
          end
        end
        FILL: begin
          timer <= timer + 1'b1;
          // A full bottle with its stopper wins over a timeout on the same cycle.
          if (!bus.pg) begin
            state <= FAULT;
          end else if (bus.ch && bus.ro) begin
            state <= SEAL;
            timer <= '0;
          end else if (bus.ch) begin
            state <= FAULT;
          end else if (timer == FILL_LAST) begin
            state <= FAULT;
          end
        end
        SEAL: begin
          timer <= timer + 1'b1;
          if (!bus.pg) begin
            state <= FAULT;
          end else if (timer == SEAL_LAST) begin
            state <= RELEASE;
            done  <= 1'b1;
            count <= count + 8'd1;
          end
        end
        RELEASE: begin
          if (!bus.pg) state <= bus.en ? CONVEY : IDLE;
        end
        FAULT: begin
          // Acknowledge only clears once the faulty bottle has been removed.
          if (bus.ack && !bus.pg) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.motor = (state == CONVEY) || (state == RELEASE);
  assign bus.ev    = (state == FILL);
  assign bus.ved   = (state == SEAL);
  assign bus.erro  = (state == FAULT);
  assign bus.done  = done;
  assign bus.count = count;

endmodule

// File: tb/tb_fill_seal_ctrl.sv
// Bench for fill_seal_ctrl: vector table, directed corner sequences and random
// sensor activity checked each cycle against a phase/elapsed-time model.
module tb_fill_seal_ctrl;
  localparam int FILL_TMO = 24;
  localparam int SEAL_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fill_seal_ctrl_if bus();

  fill_seal_ctrl #(.FILL_TMO(FILL_TMO), .SEAL_CYC(SEAL_CYC), .TMR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errs = 0;
  int checks = 0;
  int ev_seen = 0;
  int ved_seen = 0;
  int done_seen = 0;

  // Reference model: current phase, cycles already spent in it, bottles sealed.
  localparam int P_IDLE = 0, P_CONVEY = 1, P_FILL = 2, P_SEAL = 3, P_RELEASE = 4, P_FAULT = 5;
  int ph = P_IDLE;
  int elapsed = 0;
  int sealed = 0;
  bit mdone = 1'b0;

  typedef struct {
    logic        en, pg, ch, ro, ack;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit en, bit pg, bit ch, bit ro, bit ack,
                             bit mo, bit e, bit vd, bit er, bit dn, int cnt);
    vec_t r;
    r.en = en; r.pg = pg; r.ch = ch; r.ro = ro; r.ack = ack;
    r.exp = {mo, e, vd, er, dn, 8'(cnt)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] dut_out();
    return {bus.motor, bus.ev, bus.ved, bus.erro, bus.done, bus.count};
  endfunction

  function automatic logic [12:0] m_out();
    return {(ph == P_CONVEY) || (ph == P_RELEASE), ph == P_FILL, ph == P_SEAL,
            ph == P_FAULT, mdone, 8'(sealed % 256)};
  endfunction

  task automatic model_reset();
    ph = P_IDLE; elapsed = 0; sealed = 0; mdone = 1'b0;
  endtask

  task automatic enter(input int p);
    ph = p; elapsed = 0;
  endtask

  task automatic model_step();
    mdone = 1'b0;
    case (ph)
      P_IDLE:    if (bus.en) enter(P_CONVEY);
      P_CONVEY:  if (bus.pg) enter(P_FILL); else if (!bus.en) enter(P_IDLE);
      P_FILL: begin
        if (!bus.pg) enter(P_FAULT);
        else if (bus.ch && bus.ro) enter(P_SEAL);
        else if (bus.ch) enter(P_FAULT);
        else if (elapsed + 1 == FILL_TMO) enter(P_FAULT);
        else elapsed++;
      end
      P_SEAL: begin
        if (!bus.pg) enter(P_FAULT);
        else if (elapsed + 1 == SEAL_CYC) begin
          enter(P_RELEASE); mdone = 1'b1; sealed++;
        end else elapsed++;
      end
      P_RELEASE: if (!bus.pg) enter(bus.en ? P_CONVEY : P_IDLE);
      P_FAULT:   if (bus.ack && !bus.pg) enter(P_IDLE);
      default:   enter(P_IDLE);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    if (bus.ev) ev_seen++;
    if (bus.ved) ved_seen++;
    if (bus.done) done_seen++;
    chk("model", 32'(dut_out()), 32'(m_out()));
  endtask

  task automatic set_in(input bit en, input bit pg, input bit ch, input bit ro, input bit ack);
    bus.en = en; bus.pg = pg; bus.ch = ch; bus.ro = ro; bus.ack = ack;
  endtask

  task automatic bottle(input int fill_len, input bit last_en);
    set_in(1, 0, 0, 0, 0); tick();
    tick();
    bus.pg = 1'b1; tick();
    repeat (fill_len - 1) tick();
    bus.ch = 1'b1; bus.ro = 1'b1; tick();
    bus.ch = 1'b0; bus.ro = 1'b0;
    repeat (SEAL_CYC) tick();
    bus.en = last_en; tick();
    bus.pg = 1'b0; tick();
  endtask

  initial begin
    int ev_cnt;
    set_in(0, 0, 0, 0, 0);

    // Vector table: no-stopper fault, ignored ack, full seal cycle, bottle pulled.
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(0,1,0,0,1, 0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0,0, 0,1,0,0,0,0));
    tbl.push_back(v(1,1,1,1,0, 0,0,1,0,0,0));
    for (int i = 0; i < 7; i++) tbl.push_back(v(1,1,0,0,0, 0,0,1,0,0,0));
    tbl.push_back(v(1,1,0,0,0, 1,0,0,0,1,1));
    tbl.push_back(v(1,1,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(v(1,1,0,0,0, 0,1,0,0,0,1));
    tbl.push_back(v(1,0,0,0,0, 0,0,0,1,0,1));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,0,1));

    #12;
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1; rst = 1'b0; model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].en, tbl[i].pg, tbl[i].ch, tbl[i].ro, tbl[i].ack);
      tick();
      chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Fill timeout: EV for exactly FILL_TMO cycles, then latched fault.
    set_in(1, 0, 0, 0, 0); tick();
    bus.pg = 1'b1; tick();
    ev_cnt = 0;
    for (int g = 0; g < FILL_TMO + 5; g++) begin
      if (!bus.ev) break;
      ev_cnt++;
      tick();
    end
    chk("tmo_ev_cycles", 32'(ev_cnt), 32'(FILL_TMO));
    chk("tmo_erro", 32'(bus.erro), 32'd1);
    set_in(0, 1, 0, 0, 1); tick();
    chk("ack_with_pg", 32'(bus.erro), 32'd1);
    bus.pg = 1'b0; tick();
    chk("ack_clear", 32'(dut_out()), 32'h001);
    bus.ack = 1'b0;

    // Level and stopper arrive on the last allowed fill cycle.
    set_in(1, 0, 0, 0, 0); tick();
    bus.pg = 1'b1; tick();
    bus.en = 1'b0;
    repeat (FILL_TMO - 1) tick();
    chk("boundary_still_fill", 32'(bus.ev), 32'd1);
    ved_seen = 0; done_seen = 0;
    bus.ch = 1'b1; bus.ro = 1'b1; tick();
    chk("boundary_seal", 32'({bus.ved, bus.erro}), 32'b10);
    bus.ch = 1'b0; bus.ro = 1'b0;
    repeat (SEAL_CYC) tick();
    chk("boundary_ved_cycles", 32'(ved_seen), 32'(SEAL_CYC));
    chk("boundary_done", 32'(done_seen), 32'd1);
    chk("boundary_count", 32'(bus.count), 32'd2);
    bus.pg = 1'b0; tick();
    chk("boundary_idle", 32'(bus.motor), 32'd0);

    // Random sensor and panel activity against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) bus.en = ~bus.en;
      if ($urandom_range(11) == 0) bus.pg = ~bus.pg;
      if ($urandom_range(9) == 0) bus.ch = ~bus.ch;
      if ($urandom_range(9) == 0) bus.ro = ~bus.ro;
      bus.ack = ($urandom_range(3) == 0);
      tick();
    end

    set_in(0, 0, 0, 0, 0);
    rst = 1'b1; tick();
    rst = 1'b0;

    // Nominal bottle: 20 fill cycles.
    ev_seen = 0; ved_seen = 0; done_seen = 0;
    bottle(20, 1'b1);
    chk("nom_ev_cycles", 32'(ev_seen), 32'd20);
    chk("nom_ved_cycles", 32'(ved_seen), 32'(SEAL_CYC));
    chk("nom_done", 32'(done_seen), 32'd1);
    chk("nom_count", 32'(bus.count), 32'd1);

    // Asynchronous reset between edges while sealing.
    bus.pg = 1'b1; tick();
    bus.ch = 1'b1; bus.ro = 1'b1; tick();
    bus.ch = 1'b0; bus.ro = 1'b0;
    repeat (3) tick();
    chk("pre_rst_seal", 32'(bus.ved), 32'd1);
    #2; rst = 1'b1; #1;
    chk("async_rst_outputs", 32'(dut_out()), 32'd0);
    model_reset();
    set_in(1, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("first_edge_after_rst", 32'(dut_out()), 32'h1000);
    bus.en = 1'b0; tick();

    // 256 bottles wrap the counter; the last release drops to idle.
    done_seen = 0;
    for (int b = 0; b < 256; b++) bottle(3, b != 255);
    chk("wrap_done_pulses", 32'(done_seen), 32'd256);
    chk("wrap_count", 32'(bus.count), 32'd0);
    chk("wrap_idle", 32'(dut_out()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
